// File: rtl/updn_mod_counter.sv
// Up/down counter over a runtime range 0..max_val with programmable step,
// wrap or saturate at the bounds, load/clear, terminal-count pulse and sticky overflow.
module updn_mod_counter #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              up_dwn_n,
    input  logic              clr,
    input  logic              ld,
    input  logic [WIDTH-1:0]  ld_val,
    input  logic [WIDTH-1:0]  max_val,
    input  logic [STEP_W-1:0] step,
    input  logic              sat_mode,
    input  logic              ovf_clr,
    output logic [WIDTH-1:0]  cnt,
    output logic              tc,
    output logic              ovf,
    output logic              at_max,
    output logic              at_zero
);

    // One spare bit over the wider operand keeps cnt+step and cnt+modulus exact.
    localparam int AW = ((WIDTH > STEP_W) ? WIDTH : STEP_W) + 1;

    typedef enum logic [1:0] {
        OP_HOLD,
        OP_CLR,
        OP_LD,
        OP_STEP
    } op_e;

    op_e              op;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;

    logic [AW-1:0]    cnt_w, s_w, max_w, mod_w, s_mod;
    logic [AW-1:0]    up_sum, up_wrap, dn_wrap, res_w;
    logic             step_evt;
    logic [WIDTH-1:0] ld_res;
    logic             unused_hi;

    always_comb begin
        if (clr)      op = OP_CLR;
        else if (ld)  op = OP_LD;
        else if (en)  op = OP_STEP;
        else          op = OP_HOLD;
    end

    assign cnt_w = {{(AW-WIDTH){1'b0}}, cnt_q};
    assign s_w   = {{(AW-STEP_W){1'b0}}, step};
    assign max_w = {{(AW-WIDTH){1'b0}}, max_val};
    assign mod_w = max_w + 1'b1;

    // Steps longer than the range only matter modulo the range on a wrap.
    assign s_mod = s_w % mod_w;

    assign up_sum = cnt_w + s_w;

    always_comb begin
        up_wrap = cnt_w + s_mod;
        if (up_wrap >= mod_w)
            up_wrap = up_wrap - mod_w;
        dn_wrap = cnt_w + mod_w - s_mod;
        if (dn_wrap >= mod_w)
            dn_wrap = dn_wrap - mod_w;
    end

    always_comb begin
        res_w    = cnt_w;
        step_evt = 1'b0;
        if (s_w == '0) begin
            res_w    = cnt_w;
            step_evt = 1'b0;
        end else if (cnt_w > max_w) begin
            // Count left stranded above a lowered max_val.
            step_evt = 1'b1;
            res_w    = (!sat_mode && up_dwn_n) ? '0 : max_w;
        end else if (up_dwn_n) begin
            if (up_sum <= max_w) begin
                res_w = up_sum;
            end else begin
                step_evt = 1'b1;
                res_w    = sat_mode ? max_w : up_wrap;
            end
        end else begin
            if (s_w <= cnt_w) begin
                res_w = cnt_w - s_w;
            end else begin
                step_evt = 1'b1;
                res_w    = sat_mode ? '0 : dn_wrap;
            end
        end
    end

    assign unused_hi = ^res_w[AW-1:WIDTH];

    assign ld_res = (ld_val > max_val) ? max_val : ld_val;

    always_comb begin
        cnt_d = cnt_q;
        tc_d  = 1'b0;
        case (op)
            OP_CLR:  cnt_d = '0;
            OP_LD:   cnt_d = ld_res;
            OP_STEP: begin
                cnt_d = res_w[WIDTH-1:0];
                tc_d  = step_evt;
            end
            default: cnt_d = cnt_q;
        endcase
    end

    // A boundary event on the same edge as ovf_clr leaves the flag set.
    always_comb begin
        ovf_d = ovf_q;
        if (ovf_clr)
            ovf_d = 1'b0;
        if (tc_d)
            ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            tc_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tc_q  <= tc_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt     = cnt_q;
    assign tc      = tc_q;
    assign ovf     = ovf_q;
    assign at_max  = (cnt_q == max_val);
    assign at_zero = (cnt_q == '0);

endmodule
